// File: rtl/osc_multi_channel_core_if.sv
// Divider stream bundle: operand egress (dividend, divisor) and quotient ingress.
// Latency: none, wires only.
// Backpressure: plain valid/ready on both directions.
interface osc_multi_channel_core_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              div_egr_tvalid;
    logic              div_egr_tready;
    logic [DATA_W-1:0] div_egr_tdata;
    logic              div_egr_tlast;
    logic [ID_W-1:0]   div_egr_tid;

    logic              div_ing_tvalid;
    logic              div_ing_tready;
    logic [DATA_W-1:0] div_ing_tdata;
    logic              div_ing_tlast;
    logic [ID_W-1:0]   div_ing_tid;
    logic              div_ing_tuser;

    // Oscillator core side: drives operands, consumes quotients.
    modport master (
        output div_egr_tvalid, div_egr_tdata, div_egr_tlast, div_egr_tid,
        input  div_egr_tready,
        input  div_ing_tvalid, div_ing_tdata, div_ing_tlast, div_ing_tid, div_ing_tuser,
        output div_ing_tready
    );

    // Divider side.
    modport slave (
        input  div_egr_tvalid, div_egr_tdata, div_egr_tlast, div_egr_tid,
        output div_egr_tready,
        output div_ing_tvalid, div_ing_tdata, div_ing_tlast, div_ing_tid, div_ing_tuser,
        input  div_ing_tready
    );
endinterface

// File: rtl/osc_multi_channel_core.sv
// Per-channel oscillator config (enable period, duty count) sharing one external divider.
// Latency: grant to commit 9+2L cycles (L = divider latency per division); zero frequency commits after 2 cycles.
// Backpressure: operand beats hold until accepted; quotients accepted only while waiting. Optional macro OSC_MC_DIV_TIMEOUT_EN adds a quotient timeout.
module osc_multi_channel_core #(
    parameter int NR_OF_CHANNELS_P     = 4,
    parameter int SYS_CLK_FREQUENCY_P  = 250000000,
    parameter int PRIME_FREQUENCY_P    = 1000000,
    parameter int DUTY_CYCLE_DIVIDER_P = 1000,
    parameter int N_BITS_P             = 32,
    parameter int Q_BITS_P             = 11,
    parameter int AXI_DATA_WIDTH_P     = 32,
    parameter int AXI_ID_WIDTH_P       = 4,
    parameter int DIV_TIMEOUT_P        = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_frequency,
    input  logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_duty_cycle,
    osc_multi_channel_core_if.master             div_if,
    output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] ch_enable_period,
    output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] ch_duty_cycle,
    output logic [NR_OF_CHANNELS_P-1:0]          ch_commit,
`ifdef OSC_MC_DIV_TIMEOUT_EN
    output logic                                 div_timeout,
`endif
    output logic                                 busy
);
    localparam int CH_W = (NR_OF_CHANNELS_P > 1) ? $clog2(NR_OF_CHANNELS_P) : 1;
    localparam logic [N_BITS_P-1:0] DIVIDEND0 = N_BITS_P'(64'(PRIME_FREQUENCY_P) << Q_BITS_P);
    localparam logic [N_BITS_P-1:0] DIVIDEND1 =
        N_BITS_P'(64'(SYS_CLK_FREQUENCY_P / DUTY_CYCLE_DIVIDER_P) << Q_BITS_P);
    localparam logic [N_BITS_P-1:0] DUTY_MAX = N_BITS_P'(DUTY_CYCLE_DIVIDER_P - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SEND_DIVIDEND_0, S_SEND_DIVISOR_0, S_WAIT_Q0,
        S_SEND_DIVIDEND_1, S_SEND_DIVISOR_1, S_WAIT_Q1, S_SCALE, S_COMMIT
    } state_t;

    state_t                state_q, state_d;
    logic [N_BITS_P-1:0]   freq_sh_q [NR_OF_CHANNELS_P];
    logic [N_BITS_P-1:0]   duty_sh_q [NR_OF_CHANNELS_P];
    logic [NR_OF_CHANNELS_P-1:0] pending_q, pending_d;
    logic [CH_W-1:0]       rr_ptr_q, ch_q, grant_ch;
    logic                  grant_vld, grant_take;
    logic [N_BITS_P-1:0]   q0_q, q1_q, duty_res_q;
    logic [N_BITS_P-1:0]   grant_freq, q_value, duty_clamp, duty_sat;
    logic [2*N_BITS_P-1:0] duty_prod, duty_shift;
    logic                  egr_fire, q_match, abort;
    logic                  unused_ing_tlast;

    // The divider marks the last quotient beat, but each quotient is a single beat here.
    assign unused_ing_tlast = div_if.div_ing_tlast;

    assign egr_fire   = div_if.div_egr_tvalid && div_if.div_egr_tready;
    assign q_match    = div_if.div_ing_tvalid && div_if.div_ing_tready &&
                        (div_if.div_ing_tid == AXI_ID_WIDTH_P'(ch_q));
    assign q_value    = div_if.div_ing_tuser ? '1 : div_if.div_ing_tdata;
    assign grant_take = (state_q == S_IDLE) && grant_vld;
    assign grant_freq = cr_frequency[grant_ch*N_BITS_P +: N_BITS_P];

`ifdef OSC_MC_DIV_TIMEOUT_EN
    localparam int TO_W = $clog2(DIV_TIMEOUT_P + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            waiting;

    assign waiting = (state_q == S_WAIT_Q0) || (state_q == S_WAIT_Q1);
    assign abort   = waiting && !q_match && (to_cnt_q == TO_W'(DIV_TIMEOUT_P - 1));

    // Count cycles spent waiting for a matching quotient; pulse on abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q    <= '0;
            div_timeout <= 1'b0;
        end else begin
            to_cnt_q    <= (waiting && !q_match && !abort) ? to_cnt_q + 1'b1 : '0;
            div_timeout <= abort;
        end
    end
`else
    localparam int unused_div_timeout_lp = DIV_TIMEOUT_P;
    assign abort = 1'b0;
`endif

    // Round-robin pick: lowest offset from the pointer wins, so scan offsets high to low.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int k = NR_OF_CHANNELS_P - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NR_OF_CHANNELS_P;
            if (pending_q[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'(idx);
            end
        end
    end

    // A register/shadow mismatch requests work; the grant clears it as the shadows catch up.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NR_OF_CHANNELS_P; i++) begin
            if ((cr_frequency[i*N_BITS_P +: N_BITS_P] != freq_sh_q[i]) ||
                (cr_duty_cycle[i*N_BITS_P +: N_BITS_P] != duty_sh_q[i]))
                pending_d[i] = 1'b1;
            if (grant_take && (grant_ch == CH_W'(i)))
                pending_d[i] = 1'b0;
            if (abort && (ch_q == CH_W'(i)))
                pending_d[i] = 1'b1;
        end
    end

    // Duty count = q1 * clamped duty, back to integer, saturated to the word width.
    always_comb begin
        duty_clamp = (duty_sh_q[ch_q] > DUTY_MAX) ? DUTY_MAX : duty_sh_q[ch_q];
        duty_prod  = {{N_BITS_P{1'b0}}, q1_q} * {{N_BITS_P{1'b0}}, duty_clamp};
        duty_shift = duty_prod >> Q_BITS_P;
        duty_sat   = (|duty_shift[2*N_BITS_P-1:N_BITS_P]) ? '1 : duty_shift[N_BITS_P-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a zero frequency skips both divisions.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:            if (grant_vld) state_d = (grant_freq == '0) ? S_COMMIT : S_SEND_DIVIDEND_0;
            S_SEND_DIVIDEND_0: if (egr_fire) state_d = S_SEND_DIVISOR_0;
            S_SEND_DIVISOR_0:  if (egr_fire) state_d = S_WAIT_Q0;
            S_WAIT_Q0:         if (q_match) state_d = S_SEND_DIVIDEND_1;
                               else if (abort) state_d = S_IDLE;
            S_SEND_DIVIDEND_1: if (egr_fire) state_d = S_SEND_DIVISOR_1;
            S_SEND_DIVISOR_1:  if (egr_fire) state_d = S_WAIT_Q1;
            S_WAIT_Q1:         if (q_match) state_d = S_SCALE;
                               else if (abort) state_d = S_IDLE;
            S_SCALE:           state_d = S_COMMIT;
            S_COMMIT:          state_d = S_IDLE;
            default:           state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state: operand beats, quotient ready, busy.
    always_comb begin
        div_if.div_egr_tvalid = 1'b0;
        div_if.div_egr_tdata  = '0;
        div_if.div_egr_tlast  = 1'b0;
        div_if.div_egr_tid    = AXI_ID_WIDTH_P'(ch_q);
        div_if.div_ing_tready = (state_q == S_WAIT_Q0) || (state_q == S_WAIT_Q1);
        busy                  = (state_q != S_IDLE);
        unique case (state_q)
            S_SEND_DIVIDEND_0: begin div_if.div_egr_tvalid = 1'b1; div_if.div_egr_tdata = DIVIDEND0; end
            S_SEND_DIVIDEND_1: begin div_if.div_egr_tvalid = 1'b1; div_if.div_egr_tdata = DIVIDEND1; end
            S_SEND_DIVISOR_0, S_SEND_DIVISOR_1: begin
                div_if.div_egr_tvalid = 1'b1;
                div_if.div_egr_tdata  = freq_sh_q[ch_q];
                div_if.div_egr_tlast  = 1'b1;
            end
            default: ;
        endcase
    end

    // Shadows, quotients and published per-channel words.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_OF_CHANNELS_P; i++) begin
                freq_sh_q[i] <= '0;
                duty_sh_q[i] <= '0;
            end
            pending_q        <= '0;
            rr_ptr_q         <= '0;
            ch_q             <= '0;
            q0_q             <= '0;
            q1_q             <= '0;
            duty_res_q       <= '0;
            ch_enable_period <= '0;
            ch_duty_cycle    <= '0;
            ch_commit        <= '0;
        end else begin
            pending_q <= pending_d;
            ch_commit <= '0;
            if (grant_take) begin
                ch_q                <= grant_ch;
                freq_sh_q[grant_ch] <= grant_freq;
                duty_sh_q[grant_ch] <= cr_duty_cycle[grant_ch*N_BITS_P +: N_BITS_P];
                q0_q                <= '0;
                q1_q                <= '0;
                duty_res_q          <= '0;
            end
            if ((state_q == S_WAIT_Q0) && q_match) q0_q <= q_value;
            if ((state_q == S_WAIT_Q1) && q_match) q1_q <= q_value;
            if (state_q == S_SCALE) duty_res_q <= duty_sat;
            if (state_q == S_COMMIT) begin
                ch_enable_period[ch_q*N_BITS_P +: N_BITS_P] <= q0_q >> Q_BITS_P;
                ch_duty_cycle[ch_q*N_BITS_P +: N_BITS_P]    <= duty_res_q;
                ch_commit[ch_q]                             <= 1'b1;
                rr_ptr_q <= (ch_q == CH_W'(NR_OF_CHANNELS_P - 1)) ? '0 : ch_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_osc_multi_channel_core.sv
// Bench for osc_multi_channel_core: directed vectors, Q-format divider model, scoreboard.
// Latency: divider answers one cycle after the divisor beat.
// Backpressure: operand ready always high; quotient release can be throttled.
module tb_osc_multi_channel_core;
    localparam int NCH = 4;
    localparam int NB  = 32;
    localparam int QB  = 11;
    localparam int IDW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NCH*NB-1:0] cr_frequency, cr_duty_cycle, ch_enable_period, ch_duty_cycle;
    logic [NCH-1:0]    ch_commit;
    logic              busy;
`ifdef OSC_MC_DIV_TIMEOUT_EN
    logic              div_timeout;
`endif

    osc_multi_channel_core_if #(.DATA_W(NB), .ID_W(IDW)) dif ();

    osc_multi_channel_core dut (
        .clk              (clk),
        .rst              (rst),
        .cr_frequency     (cr_frequency),
        .cr_duty_cycle    (cr_duty_cycle),
        .div_if           (dif.master),
        .ch_enable_period (ch_enable_period),
        .ch_duty_cycle    (ch_duty_cycle),
        .ch_commit        (ch_commit),
`ifdef OSC_MC_DIV_TIMEOUT_EN
        .div_timeout      (div_timeout),
`endif
        .busy             (busy)
    );

    typedef struct packed { logic [31:0] dat; logic last; logic [3:0] id; } beat_t;
    typedef struct packed { int ch; logic [31:0] per; logic [31:0] duty; } cmt_t;
    typedef struct packed { logic [31:0] dat; logic [3:0] id; logic ovf; } rsp_t;

    beat_t exp_beats[$];
    cmt_t  exp_cmts[$];
    rsp_t  rsp_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    resp_budget = -1;
    logic [31:0] mdl_per [NCH];
    logic [31:0] mdl_duty[NCH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [31:0] f, input logic [31:0] d);
        cr_frequency[i*NB +: NB]  = f;
        cr_duty_cycle[i*NB +: NB] = d;
    endtask

    task automatic exp_calc(input int ch, input logic [31:0] f);
        exp_beats.push_back('{dat: 32'd2048000000, last: 1'b0, id: 4'(ch)});
        exp_beats.push_back('{dat: f,              last: 1'b1, id: 4'(ch)});
        exp_beats.push_back('{dat: 32'd512000000,  last: 1'b0, id: 4'(ch)});
        exp_beats.push_back('{dat: f,              last: 1'b1, id: 4'(ch)});
    endtask

    task automatic exp_commit(input int ch, input logic [31:0] per, input logic [31:0] duty);
        exp_cmts.push_back('{ch: ch, per: per, duty: duty});
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_beats.size() > 0 || exp_cmts.size() > 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done"}, 64'(k < budget), 64'd1);
    endtask

    // Divider model: quotient = (dividend << Q) / divisor, tuser on overflow.
    initial begin : divider
        logic [31:0] dvd;
        logic [63:0] q;
        logic        fire_ing;
        dvd = '0;
        dif.div_egr_tready = 1'b1;
        dif.div_ing_tvalid = 1'b0;
        dif.div_ing_tdata  = '0;
        dif.div_ing_tlast  = 1'b0;
        dif.div_ing_tid    = '0;
        dif.div_ing_tuser  = 1'b0;
        forever begin
            @(negedge clk);
            fire_ing = dif.div_ing_tvalid && dif.div_ing_tready;
            if (dif.div_egr_tvalid && dif.div_egr_tready && !rst) begin
                if (!dif.div_egr_tlast) dvd = dif.div_egr_tdata;
                else begin
                    if (dif.div_egr_tdata == 0) q = '1;
                    else q = ({32'd0, dvd} << QB) / {32'd0, dif.div_egr_tdata};
                    rsp_q.push_back('{dat: q[31:0], id: dif.div_egr_tid, ovf: |q[63:32]});
                end
            end
            @(posedge clk);
            #1;
            if (fire_ing) begin
                if (rsp_q.size() > 0) void'(rsp_q.pop_front());
                dif.div_ing_tvalid = 1'b0;
            end
            if (!dif.div_ing_tvalid && rsp_q.size() > 0 && resp_budget != 0) begin
                dif.div_ing_tvalid = 1'b1;
                dif.div_ing_tdata  = rsp_q[0].dat;
                dif.div_ing_tid    = rsp_q[0].id;
                dif.div_ing_tuser  = rsp_q[0].ovf;
                dif.div_ing_tlast  = 1'b1;
                if (resp_budget > 0) resp_budget--;
            end
        end
    end

    // Monitor: checks operand beats and commits against the queues, outputs against the model.
    initial begin : monitor
        beat_t eb;
        cmt_t  ec;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < NCH; i++) begin
                    mdl_per[i]  = '0;
                    mdl_duty[i] = '0;
                end
            end else begin
                if (dif.div_egr_tvalid && dif.div_egr_tready) begin
                    if (exp_beats.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL egr_unexpected: got beat %0d, expected no beat", dif.div_egr_tdata);
                    end else begin
                        eb = exp_beats.pop_front();
                        check("egr_tdata", 64'(dif.div_egr_tdata), 64'(eb.dat));
                        check("egr_tlast", 64'(dif.div_egr_tlast), 64'(eb.last));
                        check("egr_tid",   64'(dif.div_egr_tid),   64'(eb.id));
                    end
                end
                for (int i = 0; i < NCH; i++) begin
                    if (ch_commit[i]) begin
                        if (exp_cmts.size() == 0) begin
                            n_vec++; n_bad++;
                            $display("FAIL commit_unexpected: got commit on ch %0d, expected none", i);
                        end else begin
                            ec = exp_cmts.pop_front();
                            check("commit_ch", 64'(i), 64'(ec.ch));
                            mdl_per[ec.ch]  = ec.per;
                            mdl_duty[ec.ch] = ec.duty;
                        end
                    end
                end
                for (int i = 0; i < NCH; i++) begin
                    check($sformatf("ch%0d_period", i), 64'(ch_enable_period[i*NB +: NB]), 64'(mdl_per[i]));
                    check($sformatf("ch%0d_duty", i),   64'(ch_duty_cycle[i*NB +: NB]),    64'(mdl_duty[i]));
                end
            end
        end
    end

    task automatic reset_and_check(input string name);
        cr_frequency  = '0;
        cr_duty_cycle = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        dif.div_ing_tvalid = 1'b0;
        rsp_q.delete();
        resp_budget = -1;
        @(negedge clk);
        check({name, "_period_zero"}, 64'(|ch_enable_period), 64'd0);
        check({name, "_duty_zero"},   64'(|ch_duty_cycle),    64'd0);
        check({name, "_commit_zero"}, 64'(ch_commit),         64'd0);
        check({name, "_busy_zero"},   64'(busy),              64'd0);
        check({name, "_egr_tvalid"},  64'(dif.div_egr_tvalid), 64'd0);
        check({name, "_ing_tready"},  64'(dif.div_ing_tready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : stimulus
        int k;
        rst           = 1'b1;
        cr_frequency  = '0;
        cr_duty_cycle = '0;
        repeat (2) @(posedge clk);
        reset_and_check("reset");

        // Single channel, nominal values.
        @(posedge clk); #1;
        exp_calc(0, 32'd2048000);
        exp_commit(0, 32'd1000, 32'd125000);
        set_ch(0, 32'd2048000, 32'd500);
        wait_quiet("ch0_basic", 200);

        // Restart arbitration from channel 0, then change all four at once.
        reset_and_check("reset2");
        @(posedge clk); #1;
        exp_calc(0, 32'd2048000); exp_commit(0, 32'd1000, 32'd25000);
        exp_calc(1, 32'd1024000); exp_commit(1, 32'd2000, 32'd100000);
        exp_calc(2, 32'd4096000); exp_commit(2, 32'd500,  32'd124875);
        exp_calc(3, 32'd512000);  exp_commit(3, 32'd4000, 32'd0);
        set_ch(0, 32'd2048000, 32'd100);
        set_ch(1, 32'd1024000, 32'd200);
        set_ch(2, 32'd4096000, 32'd999);
        set_ch(3, 32'd512000,  32'd0);
        wait_quiet("all_four", 400);

        // Duty above the resolution limit is clamped to 999.
        @(posedge clk); #1;
        exp_calc(1, 32'd2048000);
        exp_commit(1, 32'd1000, 32'd249750);
        set_ch(1, 32'd2048000, 32'd5000);
        wait_quiet("duty_clamp", 200);

        // Zero frequency: no divider traffic, muted outputs.
        @(posedge clk); #1;
        exp_commit(2, 32'd0, 32'd0);
        set_ch(2, 32'd0, 32'd300);
        wait_quiet("zero_freq", 100);

        // Stray quotient with another channel's tid is discarded.
        @(posedge clk); #1;
        rsp_q.push_back('{dat: 32'd123, id: 4'd0, ovf: 1'b0});
        exp_calc(3, 32'd2048000);
        exp_commit(3, 32'd1000, 32'd125000);
        set_ch(3, 32'd2048000, 32'd500);
        wait_quiet("wrong_tid", 200);
        check("wrong_tid_consumed", 64'(rsp_q.size()), 64'd0);

        // Divider overflow saturates both quotients.
        @(posedge clk); #1;
        exp_calc(0, 32'd1);
        exp_commit(0, 32'h001FFFFF, 32'd1048575999);
        set_ch(0, 32'd1, 32'd500);
        wait_quiet("overflow", 200);

        // Change during a running calculation triggers a recompute.
        @(posedge clk); #1;
        exp_calc(1, 32'd1024000); exp_commit(1, 32'd2000, 32'd100000);
        exp_calc(1, 32'd1024000); exp_commit(1, 32'd2000, 32'd200000);
        set_ch(1, 32'd1024000, 32'd200);
        repeat (4) @(posedge clk);
        #1;
        set_ch(1, 32'd1024000, 32'd400);
        wait_quiet("recompute", 300);

        // Reset while parked in WAIT_Q1: calculation dropped, everything clears.
        @(posedge clk); #1;
        resp_budget = 1;
        exp_calc(2, 32'd2048000);
        set_ch(2, 32'd2048000, 32'd10);
        k = 0;
        while (exp_beats.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("wait_q1_reached", 64'(k < 100), 64'd1);
        repeat (3) @(negedge clk);
        check("busy_in_wait_q1",   64'(busy),               64'd1);
        check("tready_in_wait_q1", 64'(dif.div_ing_tready), 64'd1);
        reset_and_check("reset_mid");
        repeat (20) @(negedge clk);
        check("idle_after_reset", 64'(busy),            64'd0);
        check("no_stray_commits", 64'(exp_cmts.size()), 64'd0);
        check("no_stray_beats",   64'(exp_beats.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
